// File: rtl/count_ascii_sender.sv
// count_ascii_sender: snapshots a saturated counter value, converts it to four ASCII digits plus CR LF
// and streams the six bytes through a tx_start/tx_busy handshake. Define LEADING_ZERO_BLANK_EN to send leading zeros as spaces.
module count_ascii_sender #(
  parameter int COUNT_WIDTH = 14,
  parameter int MAX_COUNT   = 9999
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send_req,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   done
);

  // state   | meaning
  // IDLE    | wait for send_req, snapshot count_in
  // CONVERT | double-dabble, one bit per cycle
  // LOAD    | register byte for current index
  // SEND    | strobe tx_start once transmitter is free
  // WAIT    | wait for transmitter to finish the byte
  // DONE    | pulse done, release busy
  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_LOAD, S_SEND, S_WAIT, S_DONE
  } state_t;

  localparam int                     CNT_W    = $clog2(COUNT_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_C    = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(COUNT_WIDTH - 1);

  state_t                  state_q;
  logic [COUNT_WIDTH-1:0]  bin_q;
  logic [15:0]             bcd_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [2:0]              idx_q;
  logic                    wait_first_q;
  logic                    tx_start_q;
  logic [7:0]              tx_data_q;
  logic                    busy_q;
  logic                    done_q;

  logic [COUNT_WIDTH-1:0]  snap_d;
  logic [15:0]             bcd_adj_d;
  logic [16+COUNT_WIDTH-1:0] shift_d;
  logic [7:0]              byte_d;

  always_comb begin
    snap_d    = (count_in > MAX_C) ? MAX_C : count_in;
    bcd_adj_d = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shift_d = {bcd_adj_d, bin_q} << 1;

    byte_d = 8'h00;
    case (idx_q)
      3'd0:    byte_d = {4'h3, bcd_q[15:12]};
      3'd1:    byte_d = {4'h3, bcd_q[11:8]};
      3'd2:    byte_d = {4'h3, bcd_q[7:4]};
      3'd3:    byte_d = {4'h3, bcd_q[3:0]};
      3'd4:    byte_d = 8'h0D;
      3'd5:    byte_d = 8'h0A;
      default: byte_d = 8'h00;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only if it and every more significant digit are zero; ones never blanks.
    if ((idx_q == 3'd0 && bcd_q[15:12] == 4'd0) ||
        (idx_q == 3'd1 && bcd_q[15:8]  == 8'd0) ||
        (idx_q == 3'd2 && bcd_q[15:4]  == 12'd0))
      byte_d = 8'h20;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      wait_first_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (send_req) begin
            bin_q   <= snap_d;
            bcd_q   <= '0;
            cnt_q   <= LAST_BIT;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          {bcd_q, bin_q} <= shift_d;
          cnt_q          <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_LOAD;
        end
        S_LOAD: begin
          tx_data_q <= byte_d;
          state_q   <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start_q   <= 1'b1;
            wait_first_q <= 1'b1;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Transmitter busy lags start by a cycle, so the first WAIT cycle is blind.
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (!tx_busy) begin
            if (idx_q == 3'd5) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_count_ascii_sender.sv
// Self-checking bench for count_ascii_sender: transmitter model, byte scoreboard, protocol monitor.
// Honours LEADING_ZERO_BLANK_EN in its expected-byte model.
module tb_count_ascii_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req = 1'b0;
  logic [13:0] count_in = '0;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  logic model_busy = 1'b0, force_busy = 1'b0, pend = 1'b0;
  logic prev_start = 1'b0, prev_done = 1'b0;
  int   busy_cnt = 0, busy_len = 10, cyc = 0, req_cyc = 0;
  int   prot_err = 0, done_cnt = 0;
  int   n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         st_q[$];

  assign tx_busy = model_busy | force_busy;

  count_ascii_sender #(.COUNT_WIDTH(14), .MAX_COUNT(9999)) dut (
    .clk      (clk),
    .rst      (rst),
    .send_req (send_req),
    .count_in (count_in),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and transmitter model, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      model_busy = 1'b0; pend = 1'b0; busy_cnt = 0;
      prev_start = 1'b0; prev_done = 1'b0;
    end else begin
      if (tx_start && (prev_start || tx_busy)) prot_err++;
      if (done && prev_done) prot_err++;
      if (done) done_cnt++;
      if (tx_start) begin
        rx_q.push_back(tx_data);
        st_q.push_back(cyc);
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end
      if (pend) begin
        pend = 1'b0; model_busy = 1'b1; busy_cnt = busy_len;
      end
      if (tx_start) pend = 1'b1;
      prev_start = tx_start;
      prev_done  = done;
    end
  end

  function automatic logic [7:0] exp_byte(input int v, input int i);
    int s, d3, d2, d1, d0;
    logic [7:0] r;
    s  = (v > 9999) ? 9999 : v;
    d3 = s / 1000; d2 = (s / 100) % 10; d1 = (s / 10) % 10; d0 = s % 10;
    case (i)
      0: r = 8'(48 + d3);
      1: r = 8'(48 + d2);
      2: r = 8'(48 + d1);
      3: r = 8'(48 + d0);
      4: r = 8'h0D;
      default: r = 8'h0A;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((i == 0 && d3 == 0) || (i == 1 && d3 == 0 && d2 == 0) ||
        (i == 2 && d3 == 0 && d2 == 0 && d1 == 0))
      r = 8'h20;
`endif
    return r;
  endfunction

  task automatic queue_frame(input int v);
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_byte(v, i));
  endtask

  task automatic clear_sb();
    exp_q.delete(); rx_q.delete(); st_q.delete();
    done_cnt = 0; prot_err = 0;
  endtask

  task automatic pulse_req();
    @(negedge clk); send_req = 1'b1;
    @(negedge clk); req_cyc = cyc; send_req = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; logic [7:0] e, g; int lat;
    clear_sb(); busy_len = 10; count_in = 14'd1234;
    queue_frame(1234);
    pulse_req();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise got %b want 1", busy); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_done_timeout got none want done"); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL basic_after_done busy=%b done=%b want 0 0", busy, done); end
    repeat (5) @(negedge clk);
    lat = (st_q.size() > 0) ? st_q[0] - req_cyc : -1;
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL basic_first_start_latency got %0d want 16", lat); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL basic_byte%0d got %h want %h", k, g, e); end
    end
    n_cmp++; if (rx_q.size() !== 0) begin n_err++; $display("FAIL basic_extra_bytes got %0d want 0", rx_q.size()); end
    n_cmp++; if (prot_err !== 0) begin n_err++; $display("FAIL basic_protocol got %0d want 0", prot_err); end
  endtask

  task automatic test_values();
    int vals[6] = '{0, 16383, 7, 9999, 10000, 305};
    int bls[6]  = '{3, 1, 5, 2, 4, 7};
    bit ok; logic [7:0] e, g;
    for (int t = 0; t < 6; t++) begin
      clear_sb(); busy_len = bls[t]; count_in = 14'(vals[t]);
      queue_frame(vals[t]);
      pulse_req();
      wait_done(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL values_%0d_done_timeout got none want done", vals[t]); end
      repeat (5) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
        e = exp_q.pop_front();
        if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 8'hxx;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL values_%0d_byte%0d got %h want %h", vals[t], k, g, e); end
      end
      n_cmp++; if (rx_q.size() !== 0 || done_cnt !== 1 || busy !== 1'b0 || prot_err !== 0)
        begin n_err++; $display("FAIL values_%0d_frame extra=%0d done=%0d busy=%b prot=%0d want 0 1 0 0",
                                vals[t], rx_q.size(), done_cnt, busy, prot_err); end
    end
  endtask

  task automatic test_ignore_during_frame();
    bit ok; logic [7:0] e, g;
    clear_sb(); busy_len = 4; count_in = 14'd555;
    queue_frame(555);
    pulse_req();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      send_req = (i % 9 == 4);
      count_in = 14'($urandom_range(0, 16383));
    end
    send_req = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ignore_done_timeout got none want done"); end
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_restart busy got %b want 0", busy); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL ignore_byte%0d got %h want %h", k, g, e); end
    end
    n_cmp++; if (rx_q.size() !== 0) begin n_err++; $display("FAIL ignore_extra_bytes got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_busy_stall();
    bit ok; logic [7:0] e, g; int rel_cyc, lat;
    clear_sb(); busy_len = 2; count_in = 14'd321;
    queue_frame(321);
    force_busy = 1'b1;
    pulse_req();
    repeat (40) @(negedge clk);
    n_cmp++; if (st_q.size() !== 0) begin n_err++; $display("FAIL stall_no_start got %0d strobes want 0", st_q.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy got %b want 1", busy); end
    rel_cyc = cyc; force_busy = 1'b0;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_done_timeout got none want done"); end
    repeat (5) @(negedge clk);
    lat = (st_q.size() > 0) ? st_q[0] - rel_cyc : -1;
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL stall_release_latency got %0d want 1", lat); end
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL stall_byte%0d got %h want %h", k, g, e); end
    end
    n_cmp++; if (rx_q.size() !== 0 || prot_err !== 0)
      begin n_err++; $display("FAIL stall_frame extra=%0d prot=%0d want 0 0", rx_q.size(), prot_err); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; logic [7:0] e, g; int lat;
    clear_sb(); busy_len = 6; count_in = 14'd7777;
    pulse_req();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (st_q.size() >= 2) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_second_start_timeout got %0d strobes want 2", st_q.size()); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL rstmid_outputs tx_start=%b tx_data=%h busy=%b done=%b want 0 00 0 0",
                              tx_start, tx_data, busy, done); end
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    clear_sb(); busy_len = 10; count_in = 14'd42;
    queue_frame(42);
    pulse_req();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_done_timeout got none want done"); end
    repeat (5) @(negedge clk);
    lat = (st_q.size() > 0) ? st_q[0] - req_cyc : -1;
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL rstmid_first_start_latency got %0d want 16", lat); end
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL rstmid_byte%0d got %h want %h", k, g, e); end
    end
    n_cmp++; if (rx_q.size() !== 0 || done_cnt !== 1)
      begin n_err++; $display("FAIL rstmid_frame extra=%0d done=%0d want 0 1", rx_q.size(), done_cnt); end
  endtask

  task automatic test_back_to_back();
    int dn; logic [7:0] e, g;
    clear_sb(); busy_len = 3; count_in = 14'd2468;
    queue_frame(2468); queue_frame(2468);
    @(negedge clk); send_req = 1'b1;
    dn = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (dn == 2) break;
    end
    send_req = 1'b0;
    n_cmp++; if (dn !== 2) begin n_err++; $display("FAIL b2b_done_pulses got %0d want 2", dn); end
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done_cnt !== 2)
      begin n_err++; $display("FAIL b2b_end busy=%b done_cnt=%0d want 0 2", busy, done_cnt); end
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL b2b_byte%0d got %h want %h", k, g, e); end
    end
    n_cmp++; if (rx_q.size() !== 0 || prot_err !== 0)
      begin n_err++; $display("FAIL b2b_frame extra=%0d prot=%0d want 0 0", rx_q.size(), prot_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_ignore_during_frame();
    test_busy_stall();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
